// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// math_pkg / shifter_pipe
//
// Purpose:
//   Pipelined barrel shifter with valid/ready handshaking on both sides.
//   Stage 0 registers the operands, works out the range flag and reduces
//   rotate amounts mod Dw. Stages 1..Sw each shift by 2^(k-1) when amount
//   bit k-1 is set. Stage Sw drives the outputs. Sustains one result per
//   cycle, holds its output under backpressure and supports a synchronous
//   flush.
//
// Ports:
//   clk_i         in   1             clock, rising edge
//   rst_ni        in   1             asynchronous active-low reset
//   flush_i       in   1             synchronous flush, empties the pipeline
//   valid_i       in   1             input transaction valid
//   ready_o       out  1             an input can be accepted this cycle
//   data_i        in   Dw            data to shift
//   shift_i       in   Sw            shift amount
//   shift_mode_i  in   shift_mode_e  operation select
//   valid_o       out  1             result valid
//   ready_i       in   1             downstream accepts the result
//   data_o        out  Dw            shifted result
//   range_o       out  1             shift_i >= Dw was presented with this result
// -----------------------------------------------------------------------------

package math_pkg;
    typedef enum logic [2:0] {
        SLL = 3'd0,   // logical left, zero fill
        SRL = 3'd1,   // logical right, zero fill
        SRA = 3'd2,   // arithmetic right, sign fill
        SLB = 3'd3,   // rotate left
        SRB = 3'd4    // rotate right
    } shift_mode_e;
endpackage

module shifter_pipe
    import math_pkg::*;
#(
    parameter int Dw = 9,
    parameter int Sw = $clog2(Dw)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [Dw-1:0]     data_i,
    input  logic [Sw-1:0]     shift_i,
    input  shift_mode_e       shift_mode_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [Dw-1:0]     data_o,
    output logic              range_o
);

    // Dw always fits in Sw+1 bits; the Sw-bit copy is only used for the
    // rotate reduction, where the wrap of the subtraction is harmless.
    localparam logic [Sw:0]   DW_W = (Sw+1)'(Dw);
    localparam logic [Sw-1:0] DW_L = DW_W[Sw-1:0];

    // One conditional-shift step of 2^k positions (k < Sw, so n < Dw).
    function automatic logic [Dw-1:0] shift_step(
        input logic [Dw-1:0] d,
        input shift_mode_e   m,
        input logic          sign,
        input logic          en,
        input int            n
    );
        logic [Dw-1:0] res;
        res = d;
        if (en) begin
            case (m)
                SLL:     res = d << n;
                SRL:     res = d >> n;
                SRA:     res = (d >> n) | ({Dw{sign}} << (Dw - n));
                SLB:     res = (d << n) | (d >> (Dw - n));
                SRB:     res = (d >> n) | (d << (Dw - n));
                default: res = d;
            endcase
        end
        return res;
    endfunction

    // Stage bookkeeping: r_vld[s] for s = 0..Sw; index Sw is the output stage.
    logic [Sw:0]   r_vld;
    logic [Sw:0]   w_rdy;
    logic [Sw:0]   w_vin;

    // Datapath of stages 0..Sw-1; the output stage has its own registers.
    logic [Dw-1:0] r_data [Sw];
    shift_mode_e   r_mode [Sw];
    logic [Sw-1:0] r_amt  [Sw];
    logic          r_sign [Sw];
    logic          r_rng  [Sw];
    logic [Dw-1:0] w_step [Sw];

    logic [Dw-1:0] r_dout;
    logic          r_rout;

    logic          w_rng0;
    logic [Sw-1:0] w_amt0;

    // A stage can load when the output is being consumed or any stage at
    // or downstream of it holds a bubble that the pipeline can collapse.
    // NOTE: every variable written in always_comb gets a value on every path
    // before use, otherwise a latch is inferred.
    always_comb begin
        logic w_hole;
        w_hole = 1'b0;
        w_rdy  = '0;
        for (int s = Sw; s >= 0; s--) begin
            w_hole   = w_hole | ~r_vld[s];
            w_rdy[s] = ready_i | w_hole;
        end
    end

    assign w_vin = {r_vld[Sw-1:0], valid_i};

    // Normalise: rotates wrap mod Dw with a single subtraction because
    // 2^Sw < 2*Dw; shifts keep the raw amount so >= Dw drains to fill bits.
    assign w_rng0 = ({1'b0, shift_i} >= DW_W);
    assign w_amt0 = (w_rng0 && (shift_mode_i == SLB || shift_mode_i == SRB))
                  ? shift_i - DW_L : shift_i;

    always_comb begin
        for (int j = 0; j < Sw; j++) begin
            w_step[j] = shift_step(r_data[j], r_mode[j], r_sign[j],
                                   r_amt[j][j], 1 << j);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
        end else begin
            r_vld <= (w_rdy & w_vin) | (~w_rdy & r_vld);
        end
    end

    // NOTE: the inner datapath has no reset; its contents are qualified by
    // r_vld, so reset only has to clear the valid bits.
    always_ff @(posedge clk_i) begin
        if (valid_i && w_rdy[0]) begin
            r_data[0] <= data_i;
            r_mode[0] <= shift_mode_i;
            r_amt[0]  <= w_amt0;
            r_sign[0] <= data_i[Dw-1];
            r_rng[0]  <= w_rng0;
        end
        for (int k = 1; k < Sw; k++) begin
            if (r_vld[k-1] && w_rdy[k]) begin
                r_data[k] <= w_step[k-1];
                r_mode[k] <= r_mode[k-1];
                r_amt[k]  <= r_amt[k-1];
                r_sign[k] <= r_sign[k-1];
                r_rng[k]  <= r_rng[k-1];
            end
        end
    end

    // Output stage loads only real items, so data_o stays 0 from reset
    // until the first result arrives and holds while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dout <= '0;
            r_rout <= 1'b0;
        end else if (r_vld[Sw-1] && w_rdy[Sw]) begin
            r_dout <= w_step[Sw-1];
            r_rout <= r_rng[Sw-1];
        end
    end

    assign ready_o = w_rdy[0];
    assign valid_o = r_vld[Sw];
    assign data_o  = r_dout;
    assign range_o = r_rout;

endmodule

// File: tb/tb_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_shifter_pipe
//
// Purpose:
//   Self-checking bench for shifter_pipe (Dw=9, Sw=4, latency 5). Results are
//   predicted by a bit-index reference model of the shift operations and a
//   queue of accepted items; ready_o is predicted from the queue occupancy.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------

module tb_shifter_pipe;
    import math_pkg::*;

    localparam int Dw  = 9;
    localparam int Sw  = $clog2(Dw);
    localparam int Lat = Sw + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [Dw-1:0] data_i;
    logic [Sw-1:0] shift_i;
    shift_mode_e   shift_mode_i;
    logic          valid_o;
    logic          ready_i;
    logic [Dw-1:0] data_o;
    logic          range_o;

    typedef struct packed {
        logic [Dw-1:0] data;
        logic          rng;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    shifter_pipe #(.Dw(Dw), .Sw(Sw)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .shift_i      (shift_i),
        .shift_mode_i (shift_mode_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .range_o      (range_o)
    );

    // Reference: each result bit is picked from the source bit it lands
    // from, or a fill bit when that source lies outside the word.
    function automatic exp_t model(input logic [Dw-1:0] d, input shift_mode_e m, input int amt);
        exp_t e;
        int   r;
        e.rng  = (amt >= Dw);
        e.data = d;
        r      = amt % Dw;
        for (int i = 0; i < Dw; i++) begin
            case (m)
                SLL:     e.data[i] = (i - amt >= 0) ? d[i - amt] : 1'b0;
                SRL:     e.data[i] = (i + amt < Dw) ? d[i + amt] : 1'b0;
                SRA:     e.data[i] = (i + amt < Dw) ? d[i + amt] : d[Dw-1];
                SLB:     e.data[i] = d[(i - r + Dw) % Dw];
                SRB:     e.data[i] = d[(i + r) % Dw];
                default: e.data[i] = d[i];
            endcase
        end
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [Dw-1:0] d, input shift_mode_e m,
                          input logic [Sw-1:0] a);
        valid_i      = v;
        data_i       = d;
        shift_mode_i = m;
        shift_i      = a;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        set_in(1'b0, '0, SLL, '0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset valid_o: got %b want 0", valid_o); end
        n_cmp++;
        if (data_o !== '0) begin n_err++; $display("FAIL reset data_o: got %h want 000", data_o); end
        n_cmp++;
        if (range_o !== 1'b0) begin n_err++; $display("FAIL reset range_o: got %b want 0", range_o); end
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready_o: got %b want 1", ready_o); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            #1;
            n_cmp++;
            if (valid_o !== 1'b0) begin n_err++; $display("FAIL idle valid_o cycle %0d: got %b want 0", c, valid_o); end
        end
    endtask

    task automatic test_single(input string name, input logic [Dw-1:0] d, input shift_mode_e m,
                               input logic [Sw-1:0] a, input logic [Dw-1:0] exp_d, input logic exp_r);
        @(negedge clk_i);
        ready_i = 1'b1;
        set_in(1'b1, d, m, a);
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL %s ready_o: got %b want 1", name, ready_o); end
        @(negedge clk_i);
        set_in(1'b0, '0, SLL, '0);
        for (int c = 1; c <= Lat + 2; c++) begin
            #1;
            n_cmp++;
            if (valid_o !== (c == Lat)) begin
                n_err++;
                $display("FAIL %s valid_o at cycle %0d: got %b want %b", name, c, valid_o, (c == Lat));
            end
            if (c == Lat) begin
                n_cmp++;
                if (data_o !== exp_d) begin n_err++; $display("FAIL %s data_o: got %h want %h", name, data_o, exp_d); end
                n_cmp++;
                if (range_o !== exp_r) begin n_err++; $display("FAIL %s range_o: got %b want %b", name, range_o, exp_r); end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        int            sent = 0;
        int            got = 0;
        int            first = -1;
        int            last = -1;
        exp_t          e;
        logic [Dw-1:0] d;
        exp_q.delete();
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 60 && (sent < 16 || exp_q.size() > 0); cyc++) begin
            @(negedge clk_i);
            d = Dw'($urandom);
            if (sent < 16) set_in(1'b1, d, shift_mode_e'(3'(sent % 5)), Sw'(sent));
            else           set_in(1'b0, '0, SLL, '0);
            #1;
            n_cmp++;
            if (ready_o !== ((exp_q.size() < Lat) || ready_i)) begin
                n_err++; $display("FAIL stream ready_o cycle %0d: got %b", cyc, ready_o);
            end
            if (valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream spurious result: got %h want none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_o, range_o} !== {e.data, e.rng}) begin
                        n_err++;
                        $display("FAIL stream item %0d: got %h/%b want %h/%b", got, data_o, range_o, e.data, e.rng);
                    end
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(model(data_i, shift_mode_i, int'(shift_i)));
                sent++;
            end
        end
        n_cmp++;
        if (got != 16) begin n_err++; $display("FAIL stream count: got %0d want 16", got); end
        n_cmp++;
        if (last - first != 15) begin n_err++; $display("FAIL stream throughput span: got %0d want 15", last - first); end
    endtask

    task automatic test_backpressure();
        logic [Dw-1:0] d_a [8];
        shift_mode_e   m_a [8];
        logic [Sw-1:0] s_a [8];
        int            sent = 0;
        int            got = 0;
        exp_t          e;
        logic          held = 1'b0;
        logic [Dw-1:0] held_d = '0;
        logic          held_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_a[i] = Dw'($urandom);
            m_a[i] = shift_mode_e'(3'($urandom_range(0, 4)));
            s_a[i] = Sw'($urandom);
        end
        exp_q.delete();
        for (int cyc = 0; cyc < 50 && (sent < 8 || exp_q.size() > 0); cyc++) begin
            @(negedge clk_i);
            ready_i = (cyc >= 12);
            if (sent < 8) set_in(1'b1, d_a[sent], m_a[sent], s_a[sent]);
            else          set_in(1'b0, '0, SLL, '0);
            #1;
            if (cyc == 12) begin
                n_cmp++;
                if (sent != Lat) begin n_err++; $display("FAIL backpressure accepted while stalled: got %0d want %0d", sent, Lat); end
            end
            n_cmp++;
            if (ready_o !== ((exp_q.size() < Lat) || ready_i)) begin
                n_err++; $display("FAIL backpressure ready_o cycle %0d: got %b", cyc, ready_o);
            end
            if (held) begin
                n_cmp++;
                if (valid_o !== 1'b1 || data_o !== held_d || range_o !== held_r) begin
                    n_err++;
                    $display("FAIL backpressure hold: got %b/%h/%b want 1/%h/%b", valid_o, data_o, range_o, held_d, held_r);
                end
            end
            held   = (valid_o === 1'b1) && !ready_i;
            held_d = data_o;
            held_r = range_o;
            if (valid_o === 1'b1 && ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL backpressure spurious result: got %h want none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_o, range_o} !== {e.data, e.rng}) begin
                        n_err++;
                        $display("FAIL backpressure item %0d: got %h/%b want %h/%b", got, data_o, range_o, e.data, e.rng);
                    end
                end
                got++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(model(data_i, shift_mode_i, int'(shift_i)));
                sent++;
            end
        end
        n_cmp++;
        if (got != 8) begin n_err++; $display("FAIL backpressure count: got %0d want 8", got); end
    endtask

    task automatic test_random();
        exp_t e;
        int   got = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 340 && (cyc < 300 || exp_q.size() > 0); cyc++) begin
            @(negedge clk_i);
            ready_i = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (cyc < 300)
                set_in($urandom_range(0, 9) < 7, Dw'($urandom), shift_mode_e'(3'($urandom_range(0, 7))), Sw'($urandom));
            else
                set_in(1'b0, '0, SLL, '0);
            #1;
            n_cmp++;
            if (ready_o !== ((exp_q.size() < Lat) || ready_i)) begin
                n_err++; $display("FAIL random ready_o cycle %0d: got %b", cyc, ready_o);
            end
            if (valid_o === 1'b1 && ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL random spurious result: got %h want none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_o, range_o} !== {e.data, e.rng}) begin
                        n_err++;
                        $display("FAIL random item %0d: got %h/%b want %h/%b", got, data_o, range_o, e.data, e.rng);
                    end
                end
                got++;
            end
            if (valid_i && ready_o) exp_q.push_back(model(data_i, shift_mode_i, int'(shift_i)));
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL random drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            set_in(1'b1, Dw'($urandom), SRL, Sw'(i));
        end
        @(negedge clk_i);
        flush_i = 1'b1;
        set_in(1'b1, 9'h1F0, SLL, 4'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        set_in(1'b0, '0, SLL, '0);
        #1;
        n_cmp++;
        if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush valid_o: got %b want 0", valid_o); end
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush ready_o: got %b want 1", ready_o); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            #1;
            n_cmp++;
            if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush leak cycle %0d: got %b want 0", c, valid_o); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            set_in(1'b1, 9'h1F0, SRA, 4'd10);
        end
        @(negedge clk_i);
        set_in(1'b0, '0, SLL, '0);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            #1;
            seen = (valid_o === 1'b1);
        end
        n_cmp++;
        if (!seen || data_o !== 9'h1FF || range_o !== 1'b1) begin
            n_err++; $display("FAIL reset_mid prefill: got %b/%h/%b want 1/1ff/1", valid_o, data_o, range_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || data_o !== '0 || range_o !== 1'b0) begin
            n_err++; $display("FAIL reset_mid clear: got %b/%h/%b want 0/000/0", valid_o, data_o, range_o);
        end
        @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_mid ready_o: got %b want 1", ready_o); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            #1;
            n_cmp++;
            if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mid leak cycle %0d: got %b want 0", c, valid_o); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single("sra3",  9'h1F0, SRA, 4'd3,  9'h1FE, 1'b0);
        test_single("slb4",  9'h1F0, SLB, 4'd4,  9'h10F, 1'b0);
        test_single("srb11", 9'h1F0, SRB, 4'd11, 9'h07C, 1'b1);
        test_single("sll12", 9'h1F0, SLL, 4'd12, 9'h000, 1'b1);
        test_single("sra15", 9'h1F0, SRA, 4'd15, 9'h1FF, 1'b1);
        test_single("srl0",  9'h0A5, SRL, 4'd0,  9'h0A5, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
